dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single-ported data memory between the core load/store unit (c_*) and the debug/DMA port (d_*).
// - Per access: arbitrates, latches the request, and drives word address, byte write mask and lane-replicated store data.
// - Per load: extracts and sign/zero-extends the result. Also flags misaligned accesses.
// - Sequences the memory dump pulse so a dump never overlaps an access.
// PARAMETERS
// - AW  32  byte-address width of c_addr/d_addr; memory word address = addr[AW-1:2]
// PORTS
// clk                  in   1   clock, all state updates on posedge
// rst                  in   1   synchronous, active-low reset
// c_req / d_req        in   1   access request; held high until grant
// c_we / d_we          in   1   1 = store, 0 = load
// c_size / d_size      in   2   00 byte, 01 half, 10 word (11 treated as word)
// c_uns / d_uns        in   1   load zero-extend (1) / sign-extend (0)
// c_addr / d_addr      in   AW  byte address
// c_wdata / d_wdata    in   32  store data, right-aligned
// c_gnt / d_gnt        out  1   one-cycle grant; request fields latched this cycle
// c_rvalid / d_rvalid  out  1   one-cycle response strobe
// c_err / d_err        out  1   misaligned, valid with rvalid
// rdata                out  32  shared load result, valid with either rvalid
// dump_req             in   1   pulse: request memory dump
// mem_we               out  1   memory write enable
// mem_wmask            out  4   byte lane enables
// mem_addr             out  AW-2  word address
// mem_wd               out  32  store data, lane-replicated
// mem_rd               in   32  memory combinational read data
// mem_dump             out  1   one-cycle dump strobe to memory
// BEHAVIOUR
// - Reset (rst==0 at posedge): state IDLE, all outputs 0, rdata 0, dump_pending 0, priority to core. Any in-flight access is aborted: no rvalid, no write.
// - States:
//   - IDLE: dump_pending and no req -> DUMP. Any req -> grant winner, latch fields, -> ACCESS.
//   - ACCESS: drive memory from the latch; register the extracted mem_rd into rdata; -> RESP.
//   - RESP: rvalid/err to the latched owner. Re-arbitrate like IDLE, so a new gnt can issue in the same cycle -> ACCESS (throughput 1 access / 2 cycles).
//   - DUMP: mem_dump=1 for exactly one cycle, no grants; clears dump_pending; -> IDLE.
// - Latency: gnt at cycle N; memory op at N+1; rvalid at N+2.
// - Arbitration: fixed priority, core wins ties; debug is served only when c_req==0.
// - dump_req is sticky into dump_pending. It waits for a cycle in IDLE with no req; repeated pulses while pending merge into one dump.
// - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//   - mem_we stays 0 and mem_wmask = 0.
//   - rdata = 0; err = 1 with rvalid.
// - Write mask, with o = addr[1:0]:
//   - byte: 1<<o
//   - half: 0011 if o==0, 1100 if o==2
//   - word: 1111
// - Write data lanes: byte -> {4{wd[7:0]}}; half -> {2{wd[15:0]}}; word -> wd.
// - mem_we = (state==ACCESS) & we & ~misaligned & rst. It is never asserted outside ACCESS.
// - mem_addr is held at the latched word address in ACCESS, and 0 otherwise.
// - Load extraction: byte/half selected by o, shifted to bit 0, then extended per uns. rdata holds until the next ACCESS.
// - Stores also return rvalid; rdata is 0 for stores.
// CONFIGURATION
// - DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins.
//   - The last-grant pointer updates on every gnt; reset value = core last-granted, so debug wins the first tie.
// - DMEM_ARB_RR_EN undefined: fixed core priority as above; no pointer state.
// TESTING
// - Reset: hold rst=0 3 cycles with c_req=1 -> no gnt, mem_we=0, all outputs 0; release -> c_gnt next cycle.
// - Core SB 0xAB to addr 0x103 -> mem_wmask=1000, mem_wd=0xABABABAB, mem_addr=0x40; then LB from 0x103 -> rdata=0xFFFFFFAB; with c_uns=1 -> 0x000000AB.
// - Core SH to 0x102 (wd 0x1234) -> wmask=1100, mem_wd=0x12341234. SW to 0x102 -> c_err=1, mem_we=0 throughout, rdata=0.
// - c_req and d_req both high for 4 accesses -> fixed: c,c,c,c. With DMEM_ARB_RR_EN: d,c,d,c. gnt->rvalid always 2 cycles.
// - dump_req during a core access -> mem_dump exactly one cycle, only after rvalid with no req pending. Two dump_req pulses while pending -> one mem_dump.
// - Reset asserted in ACCESS of a store -> no memory write, no rvalid; state IDLE next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates core and debug/DMA accesses onto a single-ported data memory, formats store lanes,
// extracts loads and sequences memory dumps. Define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [1:0]    c_size,
  input  logic          c_uns,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_uns,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          c_gnt,
  output logic          d_gnt,
  output logic          c_rvalid,
  output logic          d_rvalid,
  output logic          c_err,
  output logic          d_err,
  output logic [31:0]   rdata,
  input  logic          dump_req,
  output logic          mem_we,
  output logic [3:0]    mem_wmask,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic          mem_dump,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester holds req and its fields stable until it sees gnt for one cycle;
  // the fields are captured on that edge, and rvalid (with err) follows exactly two cycles later.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DUMP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          lat_d;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          dump_pending;

  logic          arb_ok;
  logic          any_req;
  logic          grant;
  logic          pick_d;
  logic [1:0]    lat_off;
  logic          lat_mis;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   load_result;
  logic [3:0]    wmask_fmt;
  logic [31:0]   wd_fmt;

  assign arb_ok  = (state_q == IDLE) || (state_q == RESP);
  assign any_req = c_req | d_req;
  assign grant   = arb_ok & any_req & rst;

`ifdef DMEM_ARB_RR_EN
  logic last_d;

  // On a tie the requester that did not win last time is served.
  assign pick_d = d_req & (~c_req | ~last_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (grant) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_req & ~c_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pending requests always take precedence over a pending dump.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
        end else if (dump_pending) begin
          state_d = DUMP;
        end
      end
      ACCESS: state_d = RESP;
      RESP:   state_d = any_req ? ACCESS : IDLE;
      DUMP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      lat_d     <= pick_d;
      lat_we    <= pick_d ? d_we    : c_we;
      lat_size  <= pick_d ? d_size  : c_size;
      lat_uns   <= pick_d ? d_uns   : c_uns;
      lat_addr  <= pick_d ? d_addr  : c_addr;
      lat_wdata <= pick_d ? d_wdata : c_wdata;
    end
  end

  // Dump requests merge while one is outstanding; a pulse landing in DUMP re-arms it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dump_pending <= 1'b0;
    end else begin
      dump_pending <= (dump_pending & (state_q != DUMP)) | dump_req;
    end
  end

  assign lat_off = lat_addr[1:0];

  always_comb begin
    lat_mis = 1'b0;
    case (lat_size)
      2'b00:   lat_mis = 1'b0;
      2'b01:   lat_mis = lat_off[0];
      default: lat_mis = (lat_off != 2'b00);
    endcase
  end

  // Store formatting: byte lanes and replicated data
  always_comb begin
    wmask_fmt = 4'b0000;
    wd_fmt    = lat_wdata;
    case (lat_size)
      2'b00: begin
        wmask_fmt = 4'b0001 << lat_off;
        wd_fmt    = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        wmask_fmt = lat_off[1] ? 4'b1100 : 4'b0011;
        wd_fmt    = {2{lat_wdata[15:0]}};
      end
      default: begin
        wmask_fmt = 4'b1111;
        wd_fmt    = lat_wdata;
      end
    endcase
  end

  // Load extraction from the combinational memory read
  always_comb begin
    byte_sel = mem_rd[7:0];
    case (lat_off)
      2'd0: byte_sel = mem_rd[7:0];
      2'd1: byte_sel = mem_rd[15:8];
      2'd2: byte_sel = mem_rd[23:16];
      2'd3: byte_sel = mem_rd[31:24];
      default: byte_sel = mem_rd[7:0];
    endcase
    half_sel = lat_off[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_ext = mem_rd;
    case (lat_size)
      2'b00:   load_ext = lat_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = lat_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rd;
    endcase
    load_result = (lat_we | lat_mis) ? 32'd0 : load_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (state_q == ACCESS) begin
      rdata <= load_result;
    end
  end

  // Output logic; everything is forced low while reset is asserted.
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    c_err     = 1'b0;
    d_err     = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = 4'b0000;
    mem_addr  = '0;
    mem_wd    = 32'd0;
    mem_dump  = 1'b0;
    if (rst) begin
      c_gnt = grant & ~pick_d;
      d_gnt = grant & pick_d;
      case (state_q)
        ACCESS: begin
          mem_we    = lat_we & ~lat_mis;
          mem_wmask = lat_mis ? 4'b0000 : wmask_fmt;
          mem_addr  = lat_addr[AW-1:2];
          mem_wd    = wd_fmt;
        end
        RESP: begin
          c_rvalid = ~lat_d;
          d_rvalid = lat_d;
          c_err    = ~lat_d & lat_mis;
          d_err    = lat_d & lat_mis;
        end
        DUMP:    mem_dump = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, store/load formatting, misalignment, arbitration order,
// dump sequencing and reset during a store, against a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_uns;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic        d_req, d_we, d_uns;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err;
  logic [31:0] rdata;
  logic        dump_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [29:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_dump;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns), .c_addr(c_addr), .c_wdata(c_wdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns), .d_addr(d_addr), .d_wdata(d_wdata),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .c_err(c_err), .d_err(d_err), .rdata(rdata), .dump_req(dump_req),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_dump(mem_dump), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-masked write on the clock edge
  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access from an arbitration-capable state, with per-phase checks.
  task automatic do_access(input bit dbg, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rdata, input bit exp_err, input string tag);
    logic exp_we;
    exp_we = we & ~exp_err;
    if (dbg) begin
      d_req = 1'b1; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_size = size; c_uns = uns; c_addr = addr; c_wdata = wdata;
    end
    #1;
    check({tag, " gnt"}, {30'd0, c_gnt, d_gnt}, {30'd0, ~dbg, dbg});
    check({tag, " we@gnt"}, {31'd0, mem_we}, 32'd0);
    step();
    c_req = 1'b0;
    d_req = 1'b0;
    check({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    check({tag, " mem_addr"}, {2'd0, mem_addr}, {2'd0, addr[31:2]});
    if (exp_we || exp_err) check({tag, " wmask"}, {28'd0, mem_wmask}, {28'd0, exp_mask});
    if (exp_we) check({tag, " wd"}, mem_wd, exp_wd);
    step();
    check({tag, " rvalid"}, {30'd0, c_rvalid, d_rvalid}, {30'd0, ~dbg, dbg});
    check({tag, " err"}, {30'd0, c_err, d_err}, {30'd0, ~dbg & exp_err, dbg & exp_err});
    check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " we@resp"}, {31'd0, mem_we}, 32'd0);
    step();
  endtask

  logic arb_exp_d [4];
  int   dump_cnt;
  int   overlap;
  logic last_winner_d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
`ifdef DMEM_ARB_RR_EN
    arb_exp_d[0] = 1'b1; arb_exp_d[1] = 1'b0; arb_exp_d[2] = 1'b1; arb_exp_d[3] = 1'b0;
`else
    arb_exp_d[0] = 1'b0; arb_exp_d[1] = 1'b0; arb_exp_d[2] = 1'b0; arb_exp_d[3] = 1'b0;
`endif
    rst = 1'b0; dump_req = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_uns = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_uns = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset held three cycles with a core request pending
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst c_gnt", {31'd0, c_gnt}, 32'd0);
      check("rst mem_we", {31'd0, mem_we}, 32'd0);
      check("rst rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
      check("rst mem_dump", {31'd0, mem_dump}, 32'd0);
      check("rst rdata", rdata, 32'd0);
      check("rst mem_addr", {2'd0, mem_addr}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check("post-rst c_gnt", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    check("post-rst access we", {31'd0, mem_we}, 32'd0);
    step();
    check("post-rst rvalid", {31'd0, c_rvalid}, 32'd1);
    check("post-rst rdata", rdata, 32'd0);
    step();

    // Core byte/half/word stores and loads
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, "SB 103");
    do_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFAB, 1'b0, "LB 103");
    do_access(1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 4'b0000, 32'h0, 32'h0000_00AB, 1'b0, "LBU 103");
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h0, 1'b0, "SH 102");
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0, 32'h1234_0000, 1'b0, "LW 100");
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'h0, 1'b1, "SW 102 mis");
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0, 32'h1234_0000, 1'b0, "LW 100 after mis");

    // Debug port word store, sub-word loads, misaligned half
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, "D SW 200");
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFF0, 1'b0, "D LB 201");
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 4'b0000, 32'h0, 32'h0000_CAFE, 1'b0, "D LHU 202");
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 4'b0000, 32'h0, 32'hFFFF_CAFE, 1'b0, "D LH 202");
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, "D LH 201 mis");
    do_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, "LW size11");

    // Fresh reset so the arbitration pointer starts from its reset value
    rst = 1'b0;
    step();
    rst = 1'b1;

    // Four back-to-back contended accesses
    c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h200;
    #1;
    check("arb gnt0", {30'd0, c_gnt, d_gnt}, {30'd0, ~arb_exp_d[0], arb_exp_d[0]});
    for (int k = 1; k < 4; k++) begin
      step();
      check("arb access no gnt", {30'd0, c_gnt, d_gnt}, 32'd0);
      step();
      last_winner_d = arb_exp_d[k-1];
      check("arb rvalid", {30'd0, c_rvalid, d_rvalid}, {30'd0, ~last_winner_d, last_winner_d});
      check("arb rdata", rdata, last_winner_d ? 32'hCAFE_F00D : 32'h1234_0000);
      check("arb gnt", {30'd0, c_gnt, d_gnt}, {30'd0, ~arb_exp_d[k], arb_exp_d[k]});
    end
    step();
    c_req = 1'b0;
    d_req = 1'b0;
    step();
    check("arb rvalid3", {30'd0, c_rvalid, d_rvalid}, {30'd0, ~arb_exp_d[3], arb_exp_d[3]});
    step();

    // Dump requested during a core access
    c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 32'h100;
    #1;
    check("dump1 gnt", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    dump_req = 1'b1;
    check("dump1 no dump in access", {31'd0, mem_dump}, 32'd0);
    step();
    dump_req = 1'b0;
    check("dump1 rvalid", {31'd0, c_rvalid}, 32'd1);
    check("dump1 no dump in resp", {31'd0, mem_dump}, 32'd0);
    dump_cnt = 0;
    overlap = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_dump) dump_cnt++;
      if (mem_dump && (c_rvalid || d_rvalid || mem_we || c_gnt || d_gnt)) overlap++;
    end
    check("dump1 count", dump_cnt, 32'd1);
    check("dump1 overlap", overlap, 32'd0);

    // Two pulses merge while a second access keeps the dump waiting
    c_req = 1'b1; c_addr = 32'h200;
    #1;
    check("dump2 gnt a", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    dump_req = 1'b1;
    step();
    check("dump2 rvalid a", {31'd0, c_rvalid}, 32'd1);
    c_req = 1'b1;
    #1;
    check("dump2 regrant in resp", {31'd0, c_gnt}, 32'd1);
    check("dump2 no dump", {31'd0, mem_dump}, 32'd0);
    step();
    c_req = 1'b0;
    dump_req = 1'b0;
    check("dump2 no dump access b", {31'd0, mem_dump}, 32'd0);
    step();
    check("dump2 rvalid b", {31'd0, c_rvalid}, 32'd1);
    check("dump2 rdata b", rdata, 32'hCAFE_F00D);
    dump_cnt = 0;
    overlap = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_dump) dump_cnt++;
      if (mem_dump && (c_rvalid || d_rvalid || mem_we || c_gnt || d_gnt)) overlap++;
    end
    check("dump2 count", dump_cnt, 32'd1);
    check("dump2 overlap", overlap, 32'd0);

    // Reset arriving while a store is in ACCESS
    c_req = 1'b1; c_we = 1'b1; c_size = 2'b10; c_addr = 32'h300; c_wdata = 32'h1111_1111;
    #1;
    check("rst-store gnt", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    rst = 1'b0;
    #1;
    check("rst-store mem_we", {31'd0, mem_we}, 32'd0);
    step();
    rst = 1'b1;
    check("rst-store state idle", {30'd0, state_dbg}, 32'd0);
    check("rst-store no rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    step();
    check("rst-store no rvalid 2", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, "LW 300 unwritten");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
